// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the LEGv8 pipeline register chain and pipe_hazard_ctrl.
// Performance counter outputs exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0] id_rn;
  logic [4:0] id_rm;
  logic       id_uses_rm;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic [4:0] ex_rn;
  logic [4:0] ex_rm;
  logic       mem_reg_write;
  logic [4:0] mem_rd;
  logic       wb_reg_write;
  logic [4:0] wb_rd;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       id_ex_en;
  logic       ex_mem_en;
  logic       mem_wb_en;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       timeout_err;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [CNT_W-1:0] wait_cycles;

  modport master (
    output id_rn, id_rm, id_uses_rm, ex_mem_read, ex_rd, ex_rn, ex_rm,
           mem_reg_write, mem_rd, wb_reg_write, wb_rd, branch_taken,
           dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, timeout_err,
           stall_cycles, flush_events, wait_cycles
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rm, ex_mem_read, ex_rd, ex_rn, ex_rm,
           mem_reg_write, mem_rd, wb_reg_write, wb_rd, branch_taken,
           dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, timeout_err,
           stall_cycles, flush_events, wait_cycles
  );
`else
  modport master (
    output id_rn, id_rm, id_uses_rm, ex_mem_read, ex_rd, ex_rn, ex_rm,
           mem_reg_write, mem_rd, wb_reg_write, wb_rd, branch_taken,
           dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, timeout_err
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rm, ex_mem_read, ex_rd, ex_rn, ex_rm,
           mem_reg_write, mem_rd, wb_reg_write, wb_rd, branch_taken,
           dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, timeout_err
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage LEGv8 pipeline: stalls, flushes, freezes, forwarding.
// Define PIPE_PERF_CNT_EN to add stall/flush/wait performance counters.
//
// state    | meaning
// RUN      | pipeline advancing (normal, load-use stall or branch flush)
// MEM_WAIT | data memory busy, whole pipeline frozen
module pipe_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(WAIT_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;
  logic       freeze;
  logic       load_use;

  // XZR (31) is never a real producer, so it can neither stall nor forward.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_wr, input logic [4:0] mem_rd,
                                         input logic wb_wr, input logic [4:0] wb_rd);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_wr && mem_rd != 5'd31 && mem_rd == src)
      sel = 2'b10;
    else if (wb_wr && wb_rd != 5'd31 && wb_rd == src)
      sel = 2'b01;
    return sel;
  endfunction

  assign freeze   = bus.dmem_req & ~bus.dmem_ready;
  assign load_use = bus.ex_mem_read && bus.ex_rd != 5'd31 &&
                    (bus.ex_rd == bus.id_rn || (bus.id_uses_rm && bus.ex_rd == bus.id_rm));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    timeout_d        = timeout_q;
    bus.pc_en        = 1'b1;
    bus.if_id_en     = 1'b1;
    bus.id_ex_en     = 1'b1;
    bus.ex_mem_en    = 1'b1;
    bus.mem_wb_en    = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.fwd_a        = fwd_sel(bus.ex_rn, bus.mem_reg_write, bus.mem_rd,
                               bus.wb_reg_write, bus.wb_rd);
    bus.fwd_b        = fwd_sel(bus.ex_rm, bus.mem_reg_write, bus.mem_rd,
                               bus.wb_reg_write, bus.wb_rd);
    bus.timeout_err  = timeout_q;

    if (freeze) begin
      state_d = MEM_WAIT;
      if (wait_cnt_q == TIMEOUT_CNT)
        timeout_d = 1'b1;
      if (wait_cnt_q != 8'hff)
        wait_cnt_d = wait_cnt_q + 8'd1;
    end else if (state_q == MEM_WAIT) begin
      state_d    = RUN;
      wait_cnt_d = 8'd0;
    end

    // A taken branch held in EX/MEM during a freeze only acts once the freeze lifts.
    if (freeze) begin
      bus.pc_en     = 1'b0;
      bus.if_id_en  = 1'b0;
      bus.id_ex_en  = 1'b0;
      bus.ex_mem_en = 1'b0;
      bus.mem_wb_en = 1'b0;
    end else if (bus.branch_taken) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end

    if (!reset_n) begin
      bus.pc_en        = 1'b0;
      bus.if_id_en     = 1'b0;
      bus.id_ex_en     = 1'b0;
      bus.ex_mem_en    = 1'b0;
      bus.mem_wb_en    = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_flush = 1'b1;
      bus.fwd_a        = 2'b00;
      bus.fwd_b        = 2'b00;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;

  assign flush_evt = ~freeze & bus.branch_taken;
  assign stall_evt = ~freeze & ~bus.branch_taken & load_use;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.stall_cycles <= '0;
      bus.flush_events <= '0;
      bus.wait_cycles  <= '0;
    end else begin
      if (stall_evt)
        bus.stall_cycles <= bus.stall_cycles + 1'b1;
      if (flush_evt)
        bus.flush_events <= bus.flush_events + 1'b1;
      if (freeze)
        bus.wait_cycles <= bus.wait_cycles + 1'b1;
    end
  end
`endif

endmodule
